// File: rtl/audio_dac_serializer_if.sv
// Sample-pair write port between the filter mux (master) and the DAC serializer (slave).
interface audio_dac_serializer_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] left_channel_audio_in;
  logic [DATA_WIDTH-1:0] right_channel_audio_in;
  logic                  write;
  logic                  write_ready;

  modport master (
    output left_channel_audio_in,
    output right_channel_audio_in,
    output write,
    input  write_ready
  );

  modport slave (
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    input  write,
    output write_ready
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// Stereo sample FIFO feeding an I2S / left-justified serializer slaved to the codec's
// BCLK/LRCK, all logic in the CLOCK_50 domain.
module audio_dac_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned I2S_MODE   = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_DACLRCK,
  audio_dac_serializer_if.slave       sink,
  input  logic                        clear_underflow,
  output logic                        AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underflow
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [PtrW:0]   LevelFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntMax    = CntW'(DATA_WIDTH);
  localparam logic            LeftLevel = (I2S_MODE == 0);

  typedef enum logic [1:0] {StIdle, StLeft, StRight} state_e;

  logic [1:0] bclk_sync_q, lrck_sync_q;
  logic       bclk_prev_q, lrck_prev_q, primed_q;
  logic       bclk_fall, boundary, left_start, right_start;

  logic [DATA_WIDTH-1:0] left_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] right_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         level_q, level_d;
  logic                  fifo_empty, push, pop;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q, hold_right_q, load_word;
  logic [CntW-1:0]       cnt_q;
  logic                  lj_q, dly_q, underflow_q;

  // Two-flop synchronisers plus a history flop for fall detection.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], AUD_DACLRCK};
      bclk_prev_q <= bclk_sync_q[1];
      if (bclk_fall) begin
        lrck_prev_q <= lrck_sync_q[1];
        primed_q    <= 1'b1;
      end
    end
  end

  // The first fall after reset only records LRCK, so a stale reset value never looks like an edge.
  assign bclk_fall   = bclk_prev_q & ~bclk_sync_q[1];
  assign boundary    = bclk_fall & primed_q & (lrck_sync_q[1] != lrck_prev_q);
  assign left_start  = boundary & (lrck_sync_q[1] == LeftLevel);
  assign right_start = boundary & (lrck_sync_q[1] != LeftLevel) & (state_q != StIdle);

  assign fifo_empty       = (level_q == '0);
  assign sink.write_ready = (level_q != LevelFull);
  assign push             = sink.write & sink.write_ready;
  assign pop              = left_start & ~fifo_empty;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      left_mem[wr_ptr_q]  <= sink.left_channel_audio_in;
      right_mem[wr_ptr_q] <= sink.right_channel_audio_in;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign load_word = left_start ? (fifo_empty ? '0 : left_mem[rd_ptr_q]) : hold_right_q;

  // The boundary fall both loads the word and emits its MSB, so cnt_q restarts at 1.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      hold_right_q <= '0;
      cnt_q        <= '0;
      lj_q         <= 1'b0;
      dly_q        <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (left_start && fifo_empty) begin
        underflow_q <= 1'b1;
      end else if (clear_underflow) begin
        underflow_q <= 1'b0;
      end
      if (bclk_fall) begin
        dly_q <= lj_q;
        if (left_start || right_start) begin
          state_q <= left_start ? StLeft : StRight;
          lj_q    <= load_word[DATA_WIDTH-1];
          shift_q <= load_word << 1;
          cnt_q   <= CntW'(1);
          if (left_start) begin
            hold_right_q <= fifo_empty ? '0 : right_mem[rd_ptr_q];
          end
        end else if (state_q == StIdle) begin
          lj_q <= 1'b0;
        end else begin
          lj_q    <= (cnt_q < CntMax) ? shift_q[DATA_WIDTH-1] : 1'b0;
          shift_q <= shift_q << 1;
          if (cnt_q < CntMax) cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign AUD_DACDAT = (I2S_MODE != 0) ? dly_q : lj_q;
  assign fifo_level = level_q;
  assign underflow  = underflow_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Codec-master model driving BCLK/LRCK into an I2S and a left-justified serializer; words are
// scoreboarded against pairs queued at write time.
module tb_audio_dac_serializer;
  logic clk, rst_n, bclk, lrck, clr, frames_on;
  logic dac_a, dac_b, uf_a, uf_b;
  logic [2:0] level_a, level_b;

  audio_dac_serializer_if #(.DATA_WIDTH(32)) bus_a ();
  audio_dac_serializer_if #(.DATA_WIDTH(32)) bus_b ();

  audio_dac_serializer #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .I2S_MODE(1)) dut_i2s (
    .CLOCK_50(clk), .reset(rst_n), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .sink(bus_a.slave),
    .clear_underflow(clr), .AUD_DACDAT(dac_a), .fifo_level(level_a), .underflow(uf_a)
  );

  audio_dac_serializer #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .I2S_MODE(0)) dut_lj (
    .CLOCK_50(clk), .reset(rst_n), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .sink(bus_b.slave),
    .clear_underflow(1'b0), .AUD_DACDAT(dac_b), .fifo_level(level_b), .underflow(uf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb[$];
  int   ph = 0, bitcnt = 0, pos = 0;
  int   left_starts = 0, words_checked = 0, lj_left_id = 0, lj_word_id = -1;
  logic engaged = 0, uf_model = 0;
  logic cur_valid = 0, cur_zero = 0, done_valid = 0, done_zero = 0;
  logic [31:0] cur_exp = 0, done_exp = 0, hold_r = 0, acc = 0, lj_acc = 0, lj_word = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    engaged = 0; uf_model = 0; sb.delete();
    cur_valid = 0; cur_zero = 0; done_valid = 0; done_zero = 0;
  endtask

  task automatic half_start();
    logic [63:0] p;
    done_valid = cur_valid; done_exp = cur_exp; done_zero = cur_zero;
    if (lrck == 1'b0) begin
      cur_valid = 0; cur_zero = 0;
      if (rst_n) begin
        engaged = 1; left_starts++;
        if (sb.size() > 0) begin
          p = sb.pop_front(); cur_exp = p[63:32]; hold_r = p[31:0];
        end else begin
          cur_exp = 0; hold_r = 0; uf_model = 1;
        end
        cur_valid = 1;
      end
    end else begin
      lj_left_id++;
      cur_valid = engaged; cur_exp = hold_r; cur_zero = rst_n && !engaged;
    end
  endtask

  task automatic rise_sample();
    logic [31:0] word;
    if (pos == 0) begin
      word = {acc[30:0], dac_a};
      if (done_valid) begin
        check_val("i2s_word", word, done_exp);
        words_checked++;
      end else if (done_zero) begin
        check_val("i2s_idle_word", word, 32'h0);
      end
      acc = 0;
    end else if (pos < 32) begin
      acc = {acc[30:0], dac_a};
    end
    if (lrck && pos < 32) begin
      lj_acc = {lj_acc[30:0], dac_b};
      if (pos == 31) begin
        lj_word = lj_acc; lj_word_id = lj_left_id;
      end
    end
    if (pos < 1000) pos++;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Codec: BCLK period 16 clk, LRCK toggles on every 32nd BCLK fall while frames_on.
  initial begin : codec
    bclk = 1; lrck = 1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) model_clear();
      ph = (ph + 1) % 16;
      if (ph == 0) begin
        bclk = 0;
        if (!frames_on) begin
          cur_valid = 0; cur_zero = 0;
        end else begin
          bitcnt++;
          if (bitcnt == 32) begin
            bitcnt = 0; lrck = ~lrck; pos = 0;
            half_start();
          end
        end
      end else if (ph == 8) begin
        rise_sample();
        bclk = 1;
      end
    end
  end

  task automatic wait_ph(input int p);
    for (int i = 0; i < 32 && ph != p; i++) @(negedge clk);
  endtask

  task automatic wait_left(input int target, input string tag, output logic saw_one);
    int n = 0;
    saw_one = 0;
    while (left_starts < target && n < 8000) begin
      @(negedge clk);
      if (ph == 12) saw_one |= dac_a;
      n++;
    end
    check_val(tag, 32'(left_starts >= target), 32'h1);
  endtask

  task automatic wait_words(input int target, input string tag);
    int n = 0;
    while (words_checked < target && n < 4000) begin
      @(negedge clk); n++;
    end
    check_val(tag, 32'(words_checked >= target), 32'h1);
  endtask

  task automatic push_a(input logic [31:0] l, input logic [31:0] r);
    wait_ph(12);
    bus_a.left_channel_audio_in = l; bus_a.right_channel_audio_in = r; bus_a.write = 1;
    check_val("write_ready", bus_a.write_ready, 32'(sb.size() < 4));
    if (sb.size() < 4) sb.push_back({l, r});
    @(negedge clk);
    bus_a.write = 0;
  endtask

  task automatic check_level_a(input string tag);
    wait_ph(12);
    check_val({tag, "_level"}, level_a, sb.size());
    check_val({tag, "_ready"}, bus_a.write_ready, 32'(sb.size() < 4));
  endtask

  initial begin : main
    logic saw;
    int n, w, r;
    rst_n = 0; clr = 0; frames_on = 1;
    bus_a.write = 0; bus_a.left_channel_audio_in = 0; bus_a.right_channel_audio_in = 0;
    bus_b.write = 0; bus_b.left_channel_audio_in = 0; bus_b.right_channel_audio_in = 0;
    repeat (20) @(negedge clk);
    check_val("rst_dac", dac_a, 32'h0);
    check_val("rst_ready", bus_a.write_ready, 32'h1);
    check_val("rst_level", level_a, 32'h0);
    check_val("rst_uf", uf_a, 32'h0);
    rst_n = 1;

    // Single pair through the I2S path.
    push_a(32'hA5A5_0001, 32'h8000_00FF);
    check_level_a("t2_one");
    wait_left(left_starts + 1, "t2_first_left", saw);
    check_val("t1_quiet_before_lrck", saw, 32'h0);
    check_level_a("t2_popped");
    w = words_checked;
    wait_words(w + 2, "t2_words");

    // Empty frames: underflow set, cleared, set again.
    wait_ph(12);
    check_val("t3_uf_set", uf_a, uf_model);
    wait_left(left_starts + 2, "t3_frames", saw);
    check_val("t3_dac_zero", saw, 32'h0);
    wait_ph(12);
    clr = 1;
    @(negedge clk);
    clr = 0; uf_model = 0;
    check_val("t3_uf_clr", uf_a, uf_model);
    wait_left(left_starts + 1, "t3_next_left", saw);
    wait_ph(12);
    check_val("t3_uf_again", uf_a, uf_model);

    // Fill the FIFO with the frame clock stopped, then drain.
    frames_on = 0;
    for (int i = 0; i < 4; i++) push_a(32'h1111_0000 + i, 32'h2222_0000 + i);
    check_level_a("t4_full");
    push_a(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check_level_a("t4_overfill");
    frames_on = 1;
    n = left_starts;
    wait_left(n + 1, "t4_resume", saw);
    check_level_a("t4_after_pop");
    wait_left(n + 5, "t4_drain", saw);
    check_level_a("t4_empty");

    // Reset in the middle of a left word.
    push_a(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_left(left_starts + 1, "t5_left", saw);
    for (int i = 0; i < 400 && pos != 11; i++) @(negedge clk);
    wait_ph(12);
    check_val("t5_pre_dac", dac_a, 32'h1);
    rst_n = 0;
    #1;
    check_val("t5_rst_dac", dac_a, 32'h0);
    check_val("t5_rst_level", level_a, 32'h0);
    check_val("t5_rst_ready", bus_a.write_ready, 32'h1);
    for (int i = 0; i < 2000 && !(lrck && pos >= 4); i++) @(negedge clk);
    check_val("t5_in_right", lrck, 32'h1);
    @(negedge clk);
    rst_n = 1;
    push_a(32'h1234_5678, 32'h9ABC_DEF0);
    wait_left(left_starts + 1, "t5_restart", saw);
    check_val("t5_quiet", saw, 32'h0);
    w = words_checked;
    wait_words(w + 2, "t5_words");
    wait_ph(12);
    check_val("t5_uf", uf_a, uf_model);

    // Left-justified unit: left is LRCK high, MSB on first rise.
    for (int i = 0; i < 2000 && pos != 2; i++) @(negedge clk);
    wait_ph(12);
    r = lj_left_id;
    bus_b.left_channel_audio_in = 32'hFFFF_0000; bus_b.right_channel_audio_in = 32'h0000_FFFF;
    bus_b.write = 1;
    @(negedge clk);
    bus_b.write = 0;
    wait_ph(12);
    check_val("t6_level_one", level_b, 32'h1);
    for (int i = 0; i < 3000 && lj_word_id != r + 1; i++) @(negedge clk);
    check_val("t6_word_seen", 32'(lj_word_id == r + 1), 32'h1);
    check_val("t6_lj_word", lj_word, 32'hFFFF_0000);
    check_val("t6_lj_msb", lj_word[31], 32'h1);
    check_val("t6_level_zero", level_b, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
